// File: rtl/flash_spi_burst.sv
// rtl/flash_spi_burst.sv - SPI-flash word reader issuing READ/FAST_READ with sequential streaming
//
// Purpose: fetches 32-bit little-endian words from a SPI flash (mode 0). A request
// starts a READ (0x03) or FAST_READ (0x0B) command. After each word CS is held low, so
// a request for the next sequential word address only clocks 32 more data bits.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   rd_strb, addr         read request and word address, taken when ready=1
//   stop                  abort; closes the flash transaction next cycle
//   data, valid           received word (first wire byte in [7:0]) and its one-cycle strobe
//   ready                 request can be accepted (idle or holding CS after a word)
//   spi_cs_n, spi_sclk,   flash pins; sclk and mosi are registered, sclk idles low
//   spi_mosi, spi_miso
module flash_spi_burst #(
  parameter int ADDR_W    = 22,
  parameter int CLK_DIV   = 1,
  parameter int FAST_READ = 0,
  parameter int CS_IDLE   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_strb,
  input  logic [ADDR_W-1:0] addr,
  input  logic              stop,
  output logic [31:0]       data,
  output logic              ready,
  output logic              valid,
  output logic              spi_cs_n,
  input  logic              spi_miso,
  output logic              spi_mosi,
  output logic              spi_sclk
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_IDLE + 1);
  localparam logic [7:0]       CMD_BYTE = (FAST_READ != 0) ? 8'h0B : 8'h03;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DUMMY,
    S_DATA,
    S_HOLD,
    S_CSGAP
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [31:0]       tx_sh;
  logic [30:0]       rx_sh;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              next_ok;

  logic              accept;
  logic              seq_hit;
  logic              shifting;
  logic              bit_end;
  logic              last_bit;
  logic              load_cmd;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       cmd_word;
  logic [31:0]       rx_word;

  // Command word on the wire: opcode then the 24-bit byte address {addr, 2'b00}.
  function automatic logic [31:0] make_cmd(input logic [ADDR_W-1:0] a);
    logic [23:0] ba;
    ba = '0;
    ba[ADDR_W+1:2] = a;
    return {CMD_BYTE, ba};
  endfunction

  assign accept    = ready && rd_strb && !stop;
  assign seq_hit   = next_ok && (addr == next_addr);
  assign shifting  = (state == S_CMD) || (state == S_DUMMY) || (state == S_DATA);
  // A bit completes at the edge that ends its high phase; MISO is sampled there.
  assign bit_end   = shifting && spi_sclk && (div_cnt == DIV_LAST);
  assign last_bit  = (state == S_DUMMY) ? (bit_cnt == 6'd7) : (bit_cnt == 6'd31);
  // A command frame starts straight from idle, or once the CS gap has elapsed.
  assign load_cmd  = ((state == S_IDLE) && accept) ||
                     ((state == S_CSGAP) && (gap_cnt == GAP_LAST));
  assign load_addr = (state == S_IDLE) ? addr : cur_addr;
  assign cmd_word  = make_cmd(load_addr);
  assign rx_word   = {rx_sh, spi_miso};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CMD;
      S_CMD:   if (bit_end && last_bit) state_nxt = (FAST_READ != 0) ? S_DUMMY : S_DATA;
      S_DUMMY: if (bit_end && last_bit) state_nxt = S_DATA;
      S_DATA:  if (bit_end && last_bit) state_nxt = S_HOLD;
      S_HOLD:  if (accept) state_nxt = seq_hit ? S_DATA : S_CSGAP;
      S_CSGAP: if (gap_cnt == GAP_LAST) state_nxt = S_CMD;
      default: state_nxt = S_IDLE;
    endcase
    if (stop && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // Output decode
  always_comb begin
    ready = (state == S_IDLE) || (state == S_HOLD);
  end

  // Datapath: SPI pins, shifters, counters and the returned word
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b1;
      valid     <= 1'b0;
      data      <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cur_addr  <= '0;
      next_addr <= '0;
      next_ok   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load_cmd) begin
        if (state == S_IDLE) cur_addr <= addr;
        spi_cs_n <= 1'b0;
        spi_sclk <= 1'b0;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        spi_mosi <= cmd_word[31];
        tx_sh    <= {cmd_word[30:0], 1'b0};
      end else begin
        case (state)
          S_CMD, S_DUMMY, S_DATA: begin
            if (div_cnt == DIV_LAST) begin
              div_cnt  <= '0;
              spi_sclk <= ~spi_sclk;
              if (spi_sclk) begin
                bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
                // MOSI moves as sclk falls; it idles high once the command is out.
                if ((state == S_CMD) && !last_bit) begin
                  spi_mosi <= tx_sh[31];
                  tx_sh    <= {tx_sh[30:0], 1'b0};
                end else begin
                  spi_mosi <= 1'b1;
                end
                if (state == S_DATA) begin
                  rx_sh <= rx_word[30:0];
                  if (last_bit) begin
                    valid     <= 1'b1;
                    data      <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
                    next_addr <= cur_addr + ADDR_W'(1);
                    // A wrapped address is not contiguous in flash: force a new command.
                    next_ok   <= (cur_addr != '1);
                  end
                end
              end
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
          S_HOLD: begin
            if (accept) begin
              cur_addr <= addr;
              spi_mosi <= 1'b1;
              if (seq_hit) begin
                div_cnt <= '0;
                bit_cnt <= '0;
              end else begin
                spi_cs_n <= 1'b1;
                gap_cnt  <= '0;
              end
            end
          end
          S_CSGAP: gap_cnt <= gap_cnt + GAP_W'(1);
          default: ;
        endcase
      end
      // Abort leaves data alone; a word completing on this same edge still strobes valid.
      if (stop && (state != S_IDLE)) begin
        spi_cs_n <= 1'b1;
        spi_sclk <= 1'b0;
        spi_mosi <= 1'b1;
        div_cnt  <= '0;
        bit_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_flash_spi_burst.sv
// tb/tb_flash_spi_burst.sv - self-checking bench for flash_spi_burst with behavioural flash models
//
// Purpose: drives two instances (READ at CLK_DIV=1, FAST_READ at CLK_DIV=2), each against a
// small SPI flash model, and checks latency, CS behaviour, command bytes and returned words.
// Ports: none (top-level bench).
module tb_flash_spi_burst;

  localparam int CS_IDLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_strb;
  logic [1:0]  stop;
  logic [21:0] addr0, addr1;
  logic [31:0] data0, data1;
  logic [1:0]  ready, valid, cs_n, mosi, sclk;
  logic        miso0 = 1'b0;
  logic        miso1 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_spi_burst #(.ADDR_W(22), .CLK_DIV(1), .FAST_READ(0), .CS_IDLE(CS_IDLE)) dut0 (
    .clk(clk), .rst(rst), .rd_strb(rd_strb[0]), .addr(addr0), .stop(stop[0]),
    .data(data0), .ready(ready[0]), .valid(valid[0]), .spi_cs_n(cs_n[0]),
    .spi_miso(miso0), .spi_mosi(mosi[0]), .spi_sclk(sclk[0])
  );

  flash_spi_burst #(.ADDR_W(22), .CLK_DIV(2), .FAST_READ(1), .CS_IDLE(CS_IDLE)) dut1 (
    .clk(clk), .rst(rst), .rd_strb(rd_strb[1]), .addr(addr1), .stop(stop[1]),
    .data(data1), .ready(ready[1]), .valid(valid[1]), .spi_cs_n(cs_n[1]),
    .spi_miso(miso1), .spi_mosi(mosi[1]), .spi_sclk(sclk[1])
  );

  // Flash contents: fixed bytes at 0x40..0x47, a simple hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h40:  return 8'h78;
      24'h41:  return 8'h56;
      24'h42:  return 8'h34;
      24'h43:  return 8'h12;
      24'h44:  return 8'hEF;
      24'h45:  return 8'hBE;
      24'h46:  return 8'hAD;
      24'h47:  return 8'hDE;
      default: return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic flash_bit(input logic [23:0] start, input int idx);
    logic [7:0] b;
    b = mem_byte(start + 24'(idx / 8));
    return b[7 - (idx % 8)];
  endfunction

  function automatic logic [31:0] word_of(input logic [21:0] a);
    logic [23:0] ba;
    ba = {a, 2'b00};
    return {mem_byte(ba + 24'd3), mem_byte(ba + 24'd2), mem_byte(ba + 24'd1), mem_byte(ba)};
  endfunction

  // Flash model 0: READ, data starts after 32 command bits
  int          cnt0 = 0, ncmd0 = 0, mbad0 = 0;
  logic [31:0] sh0;
  logic [7:0]  ccmd0;
  logic [23:0] caddr0 = '0;
  always @(posedge sclk[0] or posedge cs_n[0]) begin
    if (cs_n[0]) cnt0 = 0;
    else begin
      if (cnt0 < 32) begin
        sh0 = {sh0[30:0], mosi[0]};
        if (cnt0 == 31) begin ncmd0++; ccmd0 = sh0[31:24]; caddr0 = sh0[23:0]; end
      end else if (mosi[0] !== 1'b1) mbad0++;
      cnt0++;
    end
  end
  always @(negedge sclk[0]) if (!cs_n[0] && cnt0 >= 32) miso0 = flash_bit(caddr0, cnt0 - 32);

  // Flash model 1: FAST_READ, 8 dummy bits before data
  int          cnt1 = 0, ncmd1 = 0, mbad1 = 0;
  logic [31:0] sh1;
  logic [7:0]  ccmd1;
  logic [23:0] caddr1 = '0;
  always @(posedge sclk[1] or posedge cs_n[1]) begin
    if (cs_n[1]) cnt1 = 0;
    else begin
      if (cnt1 < 32) begin
        sh1 = {sh1[30:0], mosi[1]};
        if (cnt1 == 31) begin ncmd1++; ccmd1 = sh1[31:24]; caddr1 = sh1[23:0]; end
      end else if (mosi[1] !== 1'b1) mbad1++;
      cnt1++;
    end
  end
  always @(negedge sclk[1]) if (!cs_n[1] && cnt1 >= 40) miso1 = flash_bit(caddr1, cnt1 - 40);

  // Observed output words; compared against the expected queues in sb_sync
  logic [31:0] obs0[$], obs1[$];
  logic [31:0] exp0[$], exp1[$];
  int          obs_rd[2] = '{0, 0};

  always @(negedge clk) begin
    if (valid[0] === 1'b1) obs0.push_back(data0);
    if (valid[1] === 1'b1) obs1.push_back(data1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input int g, input logic r, input logic s, input logic [21:0] a);
    rd_strb[g] = r;
    stop[g]    = s;
    if (g == 0) addr0 = a; else addr1 = a;
  endtask

  task automatic push_exp(input int g, input logic [31:0] w);
    if (g == 0) exp0.push_back(w); else exp1.push_back(w);
  endtask

  task automatic sb_sync(input int g);
    logic [31:0] o, e;
    int n, ne;
    n = (g == 0) ? obs0.size() : obs1.size();
    while (obs_rd[g] < n) begin
      o  = (g == 0) ? obs0[obs_rd[g]] : obs1[obs_rd[g]];
      obs_rd[g]++;
      ne = (g == 0) ? exp0.size() : exp1.size();
      checks++;
      if (ne == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid inst%0d: got %h expected no word", g, o);
      end else begin
        e = (g == 0) ? exp0.pop_front() : exp1.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL sb_data inst%0d: got %h expected %h", g, o, e);
        end
      end
    end
  endtask

  function automatic int ncmd(input int g);
    return (g == 0) ? ncmd0 : ncmd1;
  endfunction

  typedef struct {
    int          inst;
    logic [21:0] a;
    int          lat;
    int          cs_hi;
    int          new_cmd;
    logic [7:0]  cmd;
  } vec_t;

  vec_t vecs[9];

  task automatic run_row(input vec_t v);
    int g, c0, lat, cs_hi;
    logic [23:0] ca;
    g   = v.inst;
    c0  = ncmd(g);
    lat = -1;
    @(negedge clk);
    chk("ready_before_req", 32'(ready[g]), 32'd1);
    drive(g, 1'b1, 1'b0, v.a);
    push_exp(g, word_of(v.a));
    @(posedge clk); #1;
    drive(g, 1'b0, 1'b0, v.a);
    cs_hi = (cs_n[g] == 1'b1) ? 1 : 0;
    for (int n = 1; n <= 2000 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (valid[g]) lat = n;
      else if (cs_n[g]) cs_hi++;
    end
    chk("valid_latency", 32'(lat), 32'(v.lat));
    chk("cs_high_cycles", 32'(cs_hi), 32'(v.cs_hi));
    chk("ready_csn_on_valid", 32'({ready[g], cs_n[g]}), 32'b10);
    sb_sync(g);
    @(posedge clk); #1;
    chk("valid_one_cycle", 32'(valid[g]), 32'd0);
    chk("new_command_count", 32'(ncmd(g) - c0), 32'(v.new_cmd));
    if (v.new_cmd != 0) begin
      ca = (g == 0) ? caddr0 : caddr1;
      chk("cmd_byte", 32'((g == 0) ? ccmd0 : ccmd1), 32'(v.cmd));
      chk("cmd_addr", 32'(ca), 32'({v.a, 2'b00}));
    end
  endtask

  initial begin
    int c0, o0;
    vecs[0] = '{0, 22'h000010, 128, 0,       1, 8'h03};
    vecs[1] = '{0, 22'h000011, 64,  0,       0, 8'h03};
    vecs[2] = '{0, 22'h000020, 130, CS_IDLE, 1, 8'h03};
    vecs[3] = '{0, 22'h000021, 64,  0,       0, 8'h03};
    vecs[4] = '{0, 22'h3FFFFF, 130, CS_IDLE, 1, 8'h03};
    vecs[5] = '{0, 22'h000000, 130, CS_IDLE, 1, 8'h03};
    vecs[6] = '{1, 22'h000001, 288, 0,       1, 8'h0B};
    vecs[7] = '{1, 22'h000002, 128, 0,       0, 8'h0B};
    vecs[8] = '{1, 22'h000009, 290, CS_IDLE, 1, 8'h0B};

    rst = 1'b1; rd_strb = '0; stop = '0; addr0 = '0; addr1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins_0", 32'({cs_n[0], sclk[0], mosi[0], valid[0], ready[0]}), 32'b10101);
    chk("reset_data_0", data0, 32'h0);
    chk("reset_pins_1", 32'({cs_n[1], sclk[1], mosi[1], valid[1], ready[1]}), 32'b10101);
    chk("reset_data_1", data1, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_row(vecs[i]);

    // stop together with a sequential request in S_HOLD: request dropped
    c0 = ncmd0; o0 = obs0.size();
    @(negedge clk); drive(0, 1'b1, 1'b1, 22'h000001);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 22'h000001);
    chk("stop_hold_pins", 32'({cs_n[0], sclk[0], ready[0]}), 32'b101);
    repeat (100) @(posedge clk);
    #1;
    chk("stop_hold_no_valid", 32'(obs0.size() - o0), 32'd0);
    chk("stop_hold_no_cmd", 32'(ncmd0 - c0), 32'd0);

    // stop at data bit 10, with an ignored request while busy
    c0 = ncmd0; o0 = obs0.size();
    @(negedge clk); drive(0, 1'b1, 1'b0, 22'h000010);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 22'h000010);
    repeat (9) @(posedge clk);
    @(negedge clk); drive(0, 1'b1, 1'b0, 22'h000055);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 22'h000055);
    repeat (74) @(posedge clk);
    @(negedge clk); drive(0, 1'b0, 1'b1, 22'h000055);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 22'h000055);
    chk("stop_data_pins", 32'({cs_n[0], sclk[0], valid[0], ready[0]}), 32'b1001);
    chk("stop_data_unchanged", data0, word_of(22'h000000));
    repeat (200) @(posedge clk);
    #1;
    chk("stop_data_no_valid", 32'(obs0.size() - o0), 32'd0);
    chk("busy_req_ignored_cmds", 32'(ncmd0 - c0), 32'd1);
    chk("busy_req_ignored_addr", 32'(caddr0), 32'h000040);

    // stop sampled on the same edge that completes the word
    @(negedge clk); drive(0, 1'b1, 1'b0, 22'h000011);
    push_exp(0, word_of(22'h000011));
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 22'h000011);
    repeat (127) @(posedge clk);
    @(negedge clk); drive(0, 1'b0, 1'b1, 22'h000011);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 22'h000011);
    chk("stop_on_valid_pins", 32'({valid[0], cs_n[0]}), 32'b11);
    chk("stop_on_valid_data", data0, word_of(22'h000011));
    @(posedge clk); #1;
    chk("stop_on_valid_after", 32'({valid[0], ready[0]}), 32'b01);
    sb_sync(0);

    // reset in the middle of a command
    @(negedge clk); drive(0, 1'b1, 1'b0, 22'h000012);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 22'h000012);
    repeat (19) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_pins_0", 32'({cs_n[0], sclk[0], mosi[0], valid[0], ready[0]}), 32'b10101);
    chk("rst_cmd_data_0", data0, 32'h0);
    chk("rst_cmd_data_1", data1, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    sb_sync(0);
    sb_sync(1);
    chk("sb_pending_0", 32'(exp0.size()), 32'd0);
    chk("sb_pending_1", 32'(exp1.size()), 32'd0);
    chk("mosi_idle_high_0", 32'(mbad0), 32'd0);
    chk("mosi_idle_high_1", 32'(mbad1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
